// File: rtl/delay_prog_line.sv
// Programmable delay line: each accepted token re-emerges exactly D cycles later, D latched while idle.
// Optional sticky out-of-range flag on cfg_err when DELAY_PROG_ERR_EN is defined.
module delay_prog_line #(
   parameter int MAX_DELAY = 16,
   parameter int DATA_W    = 8,
   parameter int SEL_W     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]  dly_sel,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              cfg_err
);

   localparam int CW = $clog2(MAX_DELAY + 1);
   localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DELAY);
   localparam logic [CW-1:0]    MAX_D   = CW'(MAX_DELAY);

   logic [CW-1:0]        r_dly;
   logic [CW-1:0]        r_inFlight;
   logic                 r_busy;
   logic [MAX_DELAY-1:0] r_stageValid;
   logic [DATA_W-1:0]    r_stageData [MAX_DELAY];

   logic                 w_idle;
   logic                 w_selLow;
   logic                 w_selHigh;
   logic [CW-1:0]        w_selClamp;
   logic [CW-1:0]        w_dly;
   logic [CW-1:0]        w_tapIdx;
   logic [CW-1:0]        w_inFlightNext;
   logic [MAX_DELAY-1:0] w_nextValid;
   logic [DATA_W-1:0]    w_nextData [MAX_DELAY];
   logic                 w_tapValid;
   logic [DATA_W-1:0]    w_tapData;

   // The delay may only change when nothing is in flight, so an idle cycle uses dly_sel directly.
   assign w_idle     = (r_inFlight == '0);
   assign w_selLow   = (dly_sel == '0);
   assign w_selHigh  = (dly_sel > MAX_SEL);
   assign w_selClamp = w_selLow ? CW'(1) : (w_selHigh ? MAX_D : CW'(dly_sel));
   assign w_dly      = w_idle ? w_selClamp : r_dly;
   assign w_tapIdx   = r_dly - CW'(1);

   // Stages at or beyond the active delay are flushed so stale tokens cannot reach a later, longer tap.
   always_comb begin
      w_nextValid = '0;
      for (int k = 0; k < MAX_DELAY; k++) begin
         w_nextData[k] = '0;
      end
      w_nextValid[0] = in_valid;
      w_nextData[0]  = in_valid ? in_data : '0;
      for (int k = 1; k < MAX_DELAY; k++) begin
         if (CW'(k) < w_dly) begin
            w_nextValid[k] = r_stageValid[k-1];
            w_nextData[k]  = r_stageData[k-1];
         end
      end
   end

   always_comb begin
      w_tapValid = 1'b0;
      w_tapData  = '0;
      for (int k = 0; k < MAX_DELAY; k++) begin
         if (CW'(k) == w_tapIdx) begin
            w_tapValid = r_stageValid[k];
            w_tapData  = r_stageData[k];
         end
      end
   end

   always_comb begin
      w_inFlightNext = r_inFlight;
      if (in_valid && !w_tapValid) begin
         w_inFlightNext = r_inFlight + CW'(1);
      end else if (!in_valid && w_tapValid) begin
         w_inFlightNext = r_inFlight - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dly        <= CW'(1);
         r_inFlight   <= '0;
         r_busy       <= 1'b0;
         r_stageValid <= '0;
         r_stageData  <= '{default: '0};
      end else begin
         r_dly        <= w_dly;
         r_inFlight   <= w_inFlightNext;
         r_busy       <= (w_inFlightNext != '0);
         r_stageValid <= w_nextValid;
         r_stageData  <= w_nextData;
      end
   end

   // The tap index is frozen while any token is in flight, so the output mux is static for its lifetime.
   assign out_valid = w_tapValid;
   assign out_data  = w_tapData;
   assign busy      = r_busy;

`ifdef DELAY_PROG_ERR_EN
   logic r_cfgErr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfgErr <= 1'b0;
      end else if (w_idle && (w_selLow || w_selHigh)) begin
         r_cfgErr <= 1'b1;
      end
   end

   assign cfg_err = r_cfgErr;
`else
   assign cfg_err = 1'b0;
`endif

endmodule
